// File: rtl/s2a_arbiter.sv
// Two-client round-robin arbiter for the SDRAM s2a streaming port: one transaction in flight, gap after each grant.
// Optional read watchdog built when ARB_TIMEOUT_EN is defined.
module s2a_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 32,
    parameter int WR_GAP  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_write,
    input  logic [DATA_W-1:0] c0_writedata,
    input  logic [ADDR_W-1:0] c0_writeaddr,
    input  logic              c0_read,
    input  logic [ADDR_W-1:0] c0_readaddr,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_readdata,
    output logic              c0_readdone,
    input  logic              c1_write,
    input  logic [DATA_W-1:0] c1_writedata,
    input  logic [ADDR_W-1:0] c1_writeaddr,
    input  logic              c1_read,
    input  logic [ADDR_W-1:0] c1_readaddr,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_readdata,
    output logic              c1_readdone,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [ADDR_W-1:0] mem_writeaddr,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_readaddr,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_readdone,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR       = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_WAIT  = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    localparam logic [3:0] GAP_LAST = 4'(WR_GAP - 1);

    logic [2:0]        state_reg;
    logic              last_grant_reg;
    logic              grant_reg;
    logic [3:0]        gap_cnt_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [ADDR_W-1:0] raddr_reg;

    logic              req0;
    logic              req1;
    logic              cand;
    logic              cand_write;
    logic              timeout_hit;
    logic              rd_fire;
    logic [DATA_W-1:0] fire_data;

    // Tie goes to the client that was not served last.
    always_comb begin
        req0       = c0_write | c0_read;
        req1       = c1_write | c1_read;
        cand       = (req0 && req1) ? ~last_grant_reg : req1;
        cand_write = cand ? c1_write : c0_write;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == RD_WAIT)
                to_cnt_reg <= to_cnt_reg + 1'b1;
            else
                to_cnt_reg <= '0;
            if (timeout_hit && !mem_readdone)
                err_reg <= 1'b1;
        end
    end

    assign timeout_hit = (state_reg == RD_WAIT) && (to_cnt_reg == TO_LAST);
    assign err_timeout = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // A real completion wins over a watchdog expiry landing on the same cycle.
    assign rd_fire   = (state_reg == RD_WAIT) && (mem_readdone || timeout_hit);
    assign fire_data = mem_readdone ? mem_readdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            gap_cnt_reg    <= 4'd0;
            wdata_reg      <= '0;
            waddr_reg      <= '0;
            raddr_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_reg      <= cand;
                        last_grant_reg <= cand;
                        if (cand_write) begin
                            wdata_reg <= cand ? c1_writedata : c0_writedata;
                            waddr_reg <= cand ? c1_writeaddr : c0_writeaddr;
                            state_reg <= WR;
                        end else begin
                            raddr_reg <= cand ? c1_readaddr : c0_readaddr;
                            state_reg <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    gap_cnt_reg <= 4'd0;
                    state_reg   <= GAP;
                end
                RD_ISSUE: begin
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_fire) begin
                        gap_cnt_reg <= 4'd0;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST)
                        state_reg <= IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : client
            logic [DATA_W-1:0] data_reg;
            logic              done_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= 1'b0;
                    if (rd_fire && (grant_reg == 1'(gi))) begin
                        data_reg <= fire_data;
                        done_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign c0_readdata = client[0].data_reg;
    assign c0_readdone = client[0].done_reg;
    assign c1_readdata = client[1].data_reg;
    assign c1_readdone = client[1].done_reg;

    assign c0_ack = ((state_reg == WR) || (state_reg == RD_ISSUE)) && (grant_reg == 1'b0);
    assign c1_ack = ((state_reg == WR) || (state_reg == RD_ISSUE)) && (grant_reg == 1'b1);

    assign mem_write     = (state_reg == WR);
    assign mem_read      = (state_reg == RD_ISSUE);
    assign mem_writedata = wdata_reg;
    assign mem_writeaddr = waddr_reg;
    assign mem_readaddr  = raddr_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_s2a_arbiter.sv
// Directed bench for s2a_arbiter: reset, writes, round-robin, reads, stray/abort, write+read, optional timeout.
module tb_s2a_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int WR_GAP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              c0_write, c0_read, c1_write, c1_read;
    logic [DATA_W-1:0] c0_writedata, c1_writedata;
    logic [ADDR_W-1:0] c0_writeaddr, c1_writeaddr, c0_readaddr, c1_readaddr;
    logic              c0_ack, c1_ack, c0_readdone, c1_readdone;
    logic [DATA_W-1:0] c0_readdata, c1_readdata;
    logic              mem_write, mem_read, mem_readdone;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic [ADDR_W-1:0] mem_writeaddr, mem_readaddr;
    logic              busy, err_timeout;

    int checks = 0;
    int errors = 0;

    s2a_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_GAP(WR_GAP), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .c0_write(c0_write), .c0_writedata(c0_writedata), .c0_writeaddr(c0_writeaddr),
        .c0_read(c0_read), .c0_readaddr(c0_readaddr), .c0_ack(c0_ack),
        .c0_readdata(c0_readdata), .c0_readdone(c0_readdone),
        .c1_write(c1_write), .c1_writedata(c1_writedata), .c1_writeaddr(c1_writeaddr),
        .c1_read(c1_read), .c1_readaddr(c1_readaddr), .c1_ack(c1_ack),
        .c1_readdata(c1_readdata), .c1_readdone(c1_readdone),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_writeaddr(mem_writeaddr),
        .mem_read(mem_read), .mem_readaddr(mem_readaddr),
        .mem_readdata(mem_readdata), .mem_readdone(mem_readdone),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #10 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        c0_write = 0; c0_read = 0; c1_write = 0; c1_read = 0;
        c0_writedata = '0; c1_writedata = '0;
        c0_writeaddr = '0; c1_writeaddr = '0; c0_readaddr = '0; c1_readaddr = '0;
        mem_readdata = '0; mem_readdone = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic test_reset;
        logic [7:0] got;
        clear_inputs();
        reset = 1;
        tick(); tick();
        got = {c0_ack, c1_ack, c0_readdone, c1_readdone, mem_write, mem_read, busy, err_timeout};
        checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL reset_strobes: got %b required 00000000", got);
        end
        checks++;
        if ({mem_writedata, mem_writeaddr, mem_readaddr, c0_readdata, c1_readdata} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero data/address outputs required all 0");
        end
        reset = 0;
        tick();
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_write;
        int n;
        c0_write = 1; c0_writeaddr = 19'h00010; c0_writedata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({mem_write, c0_ack, c1_ack, mem_read} !== 4'b1100) begin
            errors++; $display("FAIL write_strobe: got mw/a0/a1/mr=%b required 1100", {mem_write, c0_ack, c1_ack, mem_read});
        end
        checks++;
        if (mem_writeaddr !== 19'h00010 || mem_writedata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_data: got addr %h data %h required 00010 deadbeef", mem_writeaddr, mem_writedata);
        end
        // Request kept high across its ack: must not be re-granted before the gap ends.
        c0_writeaddr = 19'h00020; c0_writedata = 32'h0BADF00D;
        n = 0;
        do begin
            tick(); n++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1 || mem_write !== 1'b0) begin
                    errors++; $display("FAIL write_gap: got busy %b mem_write %b required 1 0", busy, mem_write);
                end
            end
        end while (!mem_write && n < 20);
        checks++;
        if (n !== 2 + WR_GAP) begin
            errors++; $display("FAIL write_period: got %0d cycles required %0d", n, 2 + WR_GAP);
        end
        checks++;
        if (mem_writeaddr !== 19'h00020 || mem_writedata !== 32'h0BADF00D || c0_ack !== 1'b1) begin
            errors++; $display("FAIL write_second: got addr %h data %h ack %b required 00020 0badf00d 1", mem_writeaddr, mem_writedata, c0_ack);
        end
        c0_write = 0;
        repeat (6) tick();
        $display("write: c0 write issued, next grant after %0d cycles", n);
    endtask

    task automatic test_round_robin;
        int n;
        int acks;
        logic prev_mw;
        do_reset();
        c0_write = 1; c0_writeaddr = 19'h00100; c0_writedata = 32'hC0C0C0C0;
        c1_write = 1; c1_writeaddr = 19'h00200; c1_writedata = 32'hC1C1C1C1;
        acks = 0; prev_mw = 0; n = 0;
        while (acks < 4 && n < 40) begin
            tick(); n++;
            if (mem_write && prev_mw) begin
                checks++; errors++;
                $display("FAIL rr_spacing: got mem_write in consecutive cycles at cycle %0d required spacing", n);
            end
            prev_mw = mem_write;
            if (c0_ack || c1_ack) begin
                checks++;
                if ({c0_ack, c1_ack} !== ((acks % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_order: ack %0d got a0/a1=%b required client %0d", acks, {c0_ack, c1_ack}, acks % 2);
                end
                checks++;
                if (mem_writedata !== ((acks % 2 == 0) ? 32'hC0C0C0C0 : 32'hC1C1C1C1)) begin
                    errors++; $display("FAIL rr_data: ack %0d got %h", acks, mem_writedata);
                end
                acks++;
            end
        end
        checks++;
        if (acks !== 4) begin
            errors++; $display("FAIL rr_timeout: got %0d acks required 4", acks);
        end
        c0_write = 0; c1_write = 0;
        repeat (6) tick();
        $display("round_robin: %0d alternating write grants", acks);
    endtask

    task automatic test_read;
        int bad;
        c1_read = 1; c1_readaddr = 19'h7FFFF;
        tick();
        checks++;
        if ({mem_read, c1_ack, c0_ack, mem_write} !== 4'b1100 || mem_readaddr !== 19'h7FFFF) begin
            errors++; $display("FAIL read_issue: got mr/a1/a0/mw=%b addr %h required 1100 7ffff", {mem_read, c1_ack, c0_ack, mem_write}, mem_readaddr);
        end
        c1_read = 0;
        bad = 0;
        repeat (4) begin
            tick();
            if (c0_readdone || c1_readdone || !busy) bad++;
        end
        tick();
        mem_readdone = 1; mem_readdata = 32'h12345678;
        tick();
        mem_readdone = 0; mem_readdata = '0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL read_wait: got %0d bad wait cycles required 0", bad);
        end
        checks++;
        if (c1_readdone !== 1'b1 || c1_readdata !== 32'h12345678) begin
            errors++; $display("FAIL read_done: got done %b data %h required 1 12345678", c1_readdone, c1_readdata);
        end
        checks++;
        if (c0_readdone !== 1'b0 || c0_readdata !== 32'h0) begin
            errors++; $display("FAIL read_other: got c0 done %b data %h required 0 00000000", c0_readdone, c0_readdata);
        end
        tick();
        checks++;
        if (c1_readdone !== 1'b0) begin
            errors++; $display("FAIL read_pulse: got c1_readdone %b required 0", c1_readdone);
        end
        repeat (6) tick();
        $display("read: c1 read 7ffff returned %h", c1_readdata);
    endtask

    task automatic test_stray_and_abort;
        int bad;
        mem_readdone = 1; mem_readdata = 32'hAAAA5555;
        tick();
        mem_readdone = 0; mem_readdata = '0;
        tick();
        checks++;
        if (c0_readdone || c1_readdone || busy || c1_readdata !== 32'h12345678) begin
            errors++; $display("FAIL stray_done: got d0 %b d1 %b busy %b c1data %h required 0 0 0 12345678", c0_readdone, c1_readdone, busy, c1_readdata);
        end
        c0_read = 1; c0_readaddr = 19'h00123;
        tick();
        checks++;
        if (mem_read !== 1'b1 || c0_ack !== 1'b1 || mem_readaddr !== 19'h00123) begin
            errors++; $display("FAIL abort_issue: got mr %b a0 %b addr %h required 1 1 00123", mem_read, c0_ack, mem_readaddr);
        end
        c0_read = 0;
        tick(); tick();
        // Asynchronous reset in the middle of RD_WAIT.
        #3 reset = 1;
        #1;
        checks++;
        if ({c0_ack, c1_ack, c0_readdone, c1_readdone, mem_write, mem_read, busy, err_timeout} !== 8'h00 ||
            {mem_writedata, mem_writeaddr, mem_readaddr, c0_readdata, c1_readdata} !== '0) begin
            errors++; $display("FAIL abort_outputs: got busy %b nonzero outputs after reset required all 0", busy);
        end
        tick();
        reset = 0;
        bad = 0;
        mem_readdone = 1; mem_readdata = 32'h99999999;
        tick();
        mem_readdone = 0;
        repeat (4) begin
            tick();
            if (c0_readdone || c1_readdone || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL abort_done: got %0d cycles with readdone/busy required 0", bad);
        end
        $display("stray_and_abort: stray strobe ignored, reset aborted read");
    endtask

    task automatic test_write_read_same;
        int n;
        c0_write = 1; c0_writeaddr = 19'h00100; c0_writedata = 32'hCAFEF00D;
        c0_read = 1; c0_readaddr = 19'h00200;
        tick();
        checks++;
        if ({mem_write, mem_read, c0_ack} !== 3'b101 || mem_writeaddr !== 19'h00100) begin
            errors++; $display("FAIL wr_first: got mw/mr/a0=%b addr %h required 101 00100", {mem_write, mem_read, c0_ack}, mem_writeaddr);
        end
        c0_write = 0;
        n = 0;
        do begin
            tick(); n++;
        end while (!mem_read && n < 20);
        checks++;
        if (n !== 2 + WR_GAP || mem_readaddr !== 19'h00200 || c0_ack !== 1'b1) begin
            errors++; $display("FAIL rd_second: got %0d cycles addr %h ack %b required %0d 00200 1", n, mem_readaddr, c0_ack, 2 + WR_GAP);
        end
        c0_read = 0;
        tick();
        mem_readdone = 1; mem_readdata = 32'h55AA55AA;
        tick();
        mem_readdone = 0; mem_readdata = '0;
        checks++;
        if (c0_readdone !== 1'b1 || c0_readdata !== 32'h55AA55AA || c1_readdone !== 1'b0) begin
            errors++; $display("FAIL wr_rd_done: got d0 %b data %h d1 %b required 1 55aa55aa 0", c0_readdone, c0_readdata, c1_readdone);
        end
        repeat (6) tick();
        $display("write_read_same: write then read after %0d cycles", n);
    endtask

    task automatic test_timeout;
`ifdef ARB_TIMEOUT_EN
        int k;
        do_reset();
        c0_read = 1; c0_readaddr = 19'h00005;
        tick();
        c0_read = 0;
        k = 0;
        do begin
            tick(); k++;
        end while (!c0_readdone && k < 40);
        // 16 cycles in RD_WAIT, then the registered readdone.
        checks++;
        if (k !== 17 || c0_readdata !== 32'h0) begin
            errors++; $display("FAIL timeout_done: got %0d cycles data %h required 17 00000000", k, c0_readdata);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_err: got %b required 1", err_timeout);
        end
        mem_readdone = 1; mem_readdata = 32'h77777777;
        tick();
        mem_readdone = 0;
        repeat (8) tick();
        checks++;
        if (err_timeout !== 1'b1 || c0_readdata !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky: got err %b data %h busy %b required 1 0 0", err_timeout, c0_readdata, busy);
        end
        $display("timeout: readdone after %0d cycles, err_timeout sticky", k);
`else
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_tied: got %b required 0", err_timeout);
        end
        $display("timeout: feature not built, err_timeout tied low");
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_stray_and_abort();
        test_write_read_same();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2a_arbiter.md
Name: s2a_arbiter

Overview:
- Shares the single SDRAM streaming port (s2a write/read interface of the memory controller) between two requesters: client 0 = delay line, client 1 = future loop recorder.
- Round-robin arbitration, one memory transaction in flight at a time, enforced write spacing.
- Read data is routed back to the client that issued the read.
- Sits between the requesters and the memory controller, in the clk_50 domain.

Parameters:
- ADDR_W, 19, memory word address width.
- DATA_W, 32, memory data width.
- WR_GAP, 2, idle cycles inserted after every grant; legal range 1..15.
- TIMEOUT, 1024, read watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous reset, active-high.
- cN_write  in  1  write request, level, N=0,1.
- cN_writedata  in  DATA_W  write data; stable while cN_write=1.
- cN_writeaddr  in  ADDR_W  write address; stable while cN_write=1.
- cN_read  in  1  read request, level.
- cN_readaddr  in  ADDR_W  read address; stable while cN_read=1.
- cN_ack  out  1  1-cycle pulse: request accepted; client deasserts its request on this cycle.
- cN_readdata  out  DATA_W  returned read data, valid with cN_readdone.
- cN_readdone  out  1  1-cycle pulse: read data valid.
- mem_write  out  1  1-cycle write strobe to the controller.
- mem_writedata  out  DATA_W  registered write data.
- mem_writeaddr  out  ADDR_W  registered write address.
- mem_read  out  1  1-cycle read strobe.
- mem_readaddr  out  ADDR_W  registered read address.
- mem_readdata  in  DATA_W  read data from the controller.
- mem_readdone  in  1  read complete strobe.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky read-timeout flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = 1, so client 0 wins the first tie.
  - gap and timeout counters 0.
  - Reset asserted mid-transaction aborts it: no ack or readdone is issued afterwards.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, GAP.
- IDLE, cycle T:
  - If no request is present, stay in IDLE.
  - Candidate client: if exactly one client requests (cN_write|cN_read), it is the candidate. If both request, the client != last_grant is the candidate.
  - Within the candidate, write has priority over read.
  - Grant a write: go to WR; latch data and address.
  - Grant a read: go to RD_ISSUE; latch address.
  - In both cases, update last_grant.
- WR, cycle T+1: mem_write=1 and cN_ack=1 for exactly one cycle, then go to GAP.
- RD_ISSUE, cycle T+1: mem_read=1 and cN_ack=1 for one cycle, then go to RD_WAIT.
- RD_WAIT:
  - On mem_readdone=1, register mem_readdata into the granted client's cN_readdata and pulse cN_readdone on the next cycle. The other client's readdone stays 0 and its readdata is unchanged.
  - Then go to GAP.
- GAP: hold for WR_GAP cycles, then IDLE. Because WR_GAP >= 1, a request still high on its ack cycle is never re-granted.
- Latency:
  - Write: request to mem_write = 1 cycle. Back-to-back writes from one client have a period of 2+WR_GAP cycles.
  - Read: mem_readdone to cN_readdone = 1 cycle.
- mem_readdone outside RD_WAIT is ignored.
- A simultaneous write and read from the same client: the write is served first, and the read is re-arbitrated in the following IDLE.
- A request that drops before being granted is simply not served. Requests are never queued.
- Round-robin fairness: with both clients requesting continuously, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT.
  - When it reaches TIMEOUT without mem_readdone, the granted client receives cN_readdone=1 with cN_readdata=0, err_timeout is set (cleared only by reset), and the state goes to GAP.
  - A late mem_readdone is ignored.
- Undefined:
  - RD_WAIT waits indefinitely.
  - err_timeout is tied to 0 and the counter is not built.

Test Plan:
- Reset, then c0_write with addr 0x00010, data 0xDEADBEEF -> one cycle later mem_write=1, mem_writeaddr=0x00010, mem_writedata=0xDEADBEEF, c0_ack=1. Next grant is no earlier than 2+WR_GAP cycles after the request.
- c0_write and c1_write asserted in the same cycle and held, re-asserting after each ack -> ack order c0, c1, c0, c1; mem_write never asserts in consecutive cycles.
- c1_read with addr 0x7FFFF; bench returns mem_readdone 5 cycles after mem_read with data 0x12345678 -> c1_readdone=1 with c1_readdata=0x12345678 on the next cycle; c0_readdone stays 0.
- Stray mem_readdone in IDLE, then reset asserted during RD_WAIT -> no readdone pulses; all outputs 0; busy=0.
- c0 asserts both write and read simultaneously -> mem_write is issued first, then after GAP the mem_read is issued with c0's readaddr.
- With ARB_TIMEOUT_EN and TIMEOUT=16, a read with no mem_readdone -> c0_readdone=1 with data 0 at 16 cycles into RD_WAIT; err_timeout=1 and stays sticky.
